// File: rtl/aes_dec_pkg.sv
// Shared AES-128 constants, types and GF(2^8) helper for the decryption key schedule.
package aes_dec_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    // Rcon for rounds 1..10; only the top byte of each Rcon word is ever nonzero
    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    typedef logic [32*AES_NK-1:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_dec_key_sched_if.sv
// Cipher-key valid/ready bus between a key source and aes_dec_key_sched.
interface aes_dec_key_sched_if;
    import aes_dec_pkg::*;

    logic       key_valid;
    logic       key_ready;
    round_key_t key_in;

    modport master (output key_valid, output key_in, input key_ready);
    modport slave  (input key_valid, input key_in, output key_ready);

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8) then the affine map.
module aes_sbox
    import aes_dec_pkg::*;
(
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 equals x^-1 for nonzero x and maps 0 to 0, which is what the S-box needs
    always_comb begin
        sq  = byte_val;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sub_val = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_dec_key_sched.sv
// Iterative AES-128 key expansion into an 11-slot store, served in inverse-cipher order.
// Define AES_KEY_ZEROIZE_EN to clear the store on reset and on every new key.
module aes_dec_key_sched
    import aes_dec_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    aes_dec_key_sched_if.slave        key_bus,
    input  logic [3:0]                rd_round,
    output round_key_t                rd_key,
    output logic                      keys_valid,
    output logic                      done
);

    state_t     state;
    logic [3:0] cnt;
    logic       key_ready_q;
    round_key_t slots [0:AES_NR];

    logic       accept;
    logic [3:0] prev_idx;
    logic [3:0] rd_idx;
    round_key_t prev_key;
    round_key_t next_key;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] w0, w1, w2, w3;

    assign key_bus.key_ready = key_ready_q;
    assign accept   = key_bus.key_valid && key_ready_q;
    assign prev_idx = cnt - 4'd1;
    assign rd_idx   = 4'(AES_NR) - rd_round;
    assign prev_key = slots[prev_idx];
    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .byte_val (rot_word[8*b +: 8]),
            .sub_val  (sub_word[8*b +: 8])
        );
    end

    assign w0 = prev_key[127:96] ^ sub_word ^ {RCON[cnt], 24'h0};
    assign w1 = prev_key[95:64] ^ w0;
    assign w2 = prev_key[63:32] ^ w1;
    assign w3 = prev_key[31:0]  ^ w2;
    assign next_key = {w0, w1, w2, w3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            key_ready_q <= 1'b1;
            keys_valid  <= 1'b0;
            done        <= 1'b0;
            rd_key      <= '0;
        end else begin
            done   <= 1'b0;
            rd_key <= (keys_valid && rd_round <= 4'd10) ? slots[rd_idx] : '0;
            case (state)
                IDLE, READY: begin
                    if (accept) begin
                        cnt         <= 4'd1;
                        state       <= EXPAND;
                        keys_valid  <= 1'b0;
                        key_ready_q <= 1'b0;
                    end
                end
                EXPAND: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(AES_NR)) begin
                        cnt         <= 4'd0;
                        state       <= READY;
                        keys_valid  <= 1'b1;
                        done        <= 1'b1;
                        key_ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Without zeroization the store is never cleared; keys_valid gating hides stale slots
    always_ff @(posedge clk) begin
`ifdef AES_KEY_ZEROIZE_EN
        if (rst) begin
            for (int i = 0; i <= AES_NR; i++) slots[i] <= '0;
        end else
`endif
        if (!rst) begin
            if (accept) begin
                slots[0] <= key_bus.key_in;
`ifdef AES_KEY_ZEROIZE_EN
                for (int i = 1; i <= AES_NR; i++) slots[i] <= '0;
`endif
            end else if (state == EXPAND) begin
                slots[cnt] <= next_key;
            end
        end
    end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Scoreboard bench for aes_dec_key_sched: a word-wise FIPS-197 model plus published vectors.
module tb_aes_dec_key_sched;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         keys_valid;
    logic         done;

    aes_dec_key_sched_if key_bus();

    aes_dec_key_sched dut (
        .clk        (clk),
        .rst        (rst),
        .key_bus    (key_bus),
        .rd_round   (rd_round),
        .rd_key     (rd_key),
        .keys_valid (keys_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] sb [$];
    logic [127:0] model_sched [0:10];

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Brute-force inverse and bitwise affine form, deliberately unlike the RTL S-box
    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        s = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = s[i] ^ inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                        ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
        return s;
    endfunction

    task automatic compute_schedule(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key_bus.key_valid = 1'b0;
        key_bus.key_in = '0;
        rd_round = 4'd0;
        tick();
        tick();
        n_cmp++; if (key_bus.key_ready !== 1'b1) begin n_err++; $display("FAIL reset_key_ready: got %0b want 1", key_bus.key_ready); end
        n_cmp++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL reset_keys_valid: got %0b want 0", keys_valid); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done); end
        n_cmp++; if (rd_key !== 128'h0) begin n_err++; $display("FAIL reset_rd_key: got %h want 0", rd_key); end
        rst = 1'b0;
        tick();
    endtask

    // Accepts a key, then walks EXPAND checking ready, zero reads and the done latency
    task automatic run_expansion(input logic [127:0] key, input bit hold);
        int           cycles = 0;
        bit           seen = 1'b0;
        logic [127:0] want;
        key_bus.key_valid = 1'b1;
        key_bus.key_in = key;
        tick();
        if (!hold) key_bus.key_valid = 1'b0;
        n_cmp++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL accept_keys_valid: got %0b want 0", keys_valid); end
        n_cmp++; if (key_bus.key_ready !== 1'b0) begin n_err++; $display("FAIL accept_key_ready: got %0b want 0", key_bus.key_ready); end
        while (!seen && cycles < 20) begin
            rd_round = 4'(cycles);
            sb.push_back(128'h0);
            if (hold) key_bus.key_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            cycles++;
            want = sb.pop_front();
            n_cmp++; if (rd_key !== want) begin n_err++; $display("FAIL expand_read c%0d: got %h want %h", cycles, rd_key, want); end
            if (done === 1'b1) seen = 1'b1;
            else begin
                n_cmp++; if (key_bus.key_ready !== 1'b0) begin n_err++; $display("FAIL expand_key_ready c%0d: got %0b want 0", cycles, key_bus.key_ready); end
            end
        end
        key_bus.key_valid = 1'b0;
        n_cmp++; if (!seen || cycles != 10) begin n_err++; $display("FAIL done_latency: got %0d edges (seen=%0b) want 10", cycles, seen); end
        n_cmp++; if (keys_valid !== 1'b1) begin n_err++; $display("FAIL done_keys_valid: got %0b want 1", keys_valid); end
        n_cmp++; if (key_bus.key_ready !== 1'b1) begin n_err++; $display("FAIL done_key_ready: got %0b want 1", key_bus.key_ready); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %0b want 0", done); end
    endtask

    task automatic test_read_schedule(input string tag);
        logic [127:0] want;
        for (int r = 0; r < 16; r++) begin
            rd_round = 4'(r);
            sb.push_back(r <= 10 ? model_sched[10 - r] : 128'h0);
            tick();
            want = sb.pop_front();
            n_cmp++; if (rd_key !== want) begin n_err++; $display("FAIL %s_rd%0d: got %h want %h", tag, r, rd_key, want); end
        end
    endtask

    task automatic test_read_anchors;
        logic [3:0]   rounds [4] = '{4'd0, 4'd9, 4'd10, 4'd12};
        logic [127:0] wants  [4] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                                     128'ha0fafe1788542cb123a339392a6c7605,
                                     KEY_A, 128'h0};
        logic [127:0] want;
        for (int i = 0; i < 4; i++) begin
            rd_round = rounds[i];
            sb.push_back(wants[i]);
            tick();
            want = sb.pop_front();
            n_cmp++; if (rd_key !== want) begin n_err++; $display("FAIL anchor_rd%0d: got %h want %h", rounds[i], rd_key, want); end
        end
    endtask

    task automatic test_rekey;
        logic [127:0] want;
        compute_schedule(KEY_B);
        run_expansion(KEY_B, 1'b0);
        rd_round = 4'd0;
        sb.push_back(128'h13111d7fe3944a17f307a78b4d2b30c5);
        tick();
        want = sb.pop_front();
        n_cmp++; if (rd_key !== want) begin n_err++; $display("FAIL rekey_rd0: got %h want %h", rd_key, want); end
        test_read_schedule("rekey");
    endtask

    task automatic test_reset_mid_expand;
        bit seen_done = 1'b0;
        key_bus.key_valid = 1'b1;
        key_bus.key_in = KEY_A;
        tick();
        key_bus.key_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL midrst_keys_valid: got %0b want 0", keys_valid); end
        n_cmp++; if (key_bus.key_ready !== 1'b1) begin n_err++; $display("FAIL midrst_key_ready: got %0b want 1", key_bus.key_ready); end
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            tick();
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL midrst_no_done: got %0b want 0", seen_done); end
        compute_schedule(KEY_A);
        run_expansion(KEY_A, 1'b0);
        test_read_schedule("midrst");
    endtask

    task automatic test_rst_wins;
        bit seen_done = 1'b0;
        rst = 1'b1;
        key_bus.key_valid = 1'b1;
        key_bus.key_in = KEY_B;
        tick();
        rst = 1'b0;
        key_bus.key_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            tick();
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL rstwins_no_done: got %0b want 0", seen_done); end
        n_cmp++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL rstwins_keys_valid: got %0b want 0", keys_valid); end
        n_cmp++; if (key_bus.key_ready !== 1'b1) begin n_err++; $display("FAIL rstwins_key_ready: got %0b want 1", key_bus.key_ready); end
    endtask

    task automatic test_hold_valid;
        compute_schedule(KEY_A);
        run_expansion(KEY_A, 1'b1);
        test_read_schedule("hold");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        compute_schedule(KEY_A);
        run_expansion(KEY_A, 1'b0);
        test_read_anchors();
        test_read_schedule("keya");
        test_rekey();
        test_reset_mid_expand();
        test_rst_wins();
        test_hold_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
